// File: rtl/uart_mem_cmd.sv
// Byte-stream command engine (A/W/R/B) between a uart rx/tx pair and a DATA_W x DEPTH synchronous RAM.
// Latency: 'K' 2 cycles after the last arg byte, first read byte 3 cycles after the trigger; tx_wait stalls tx_we/tx_data.
module uart_mem_cmd #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 65536,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_we,
  input  logic              tx_wait,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              err_overrun,
  output logic              err_timeout
);

  localparam int          DATA_BYTES = (DATA_W + 7) / 8;
  localparam int          ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int          TMO_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TMO_EN     = (TIMEOUT != 0);
  localparam logic [31:0] DEPTH_U    = DEPTH;

  localparam logic [7:0] CMD_A = 8'h41;
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_B = 8'h42;

  typedef enum logic [2:0] {
    S_IDLE, S_ARGS, S_EXEC, S_RD_REQ, S_RD_WAIT, S_SEND, S_RESP
  } state_t;

  state_t             state, state_nxt;
  logic [7:0]         cmd_q;
  logic [31:0]        arg_q;
  logic [2:0]         arg_cnt;
  logic [2:0]         arg_need;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [7:0]         burst_q;
  logic [1:0]         byte_idx;
  logic [DATA_W-1:0]  rd_word;
  logic [DATA_W-1:0]  ram_q;
  logic [7:0]         resp_q;
  logic [31:0]        rd_pad;
  logic [ADDR_W-1:0]  addr_inc;
  logic               arg_last, tmo_hit, tx_accept, send_last, mem_we;

  logic [DATA_W-1:0]  mem [DEPTH];

  always_comb begin
    arg_need = 3'd1;
    if (cmd_q == CMD_A)      arg_need = 3'(ADDR_BYTES);
    else if (cmd_q == CMD_W) arg_need = 3'(DATA_BYTES);
  end

  assign arg_last  = rx_valid && (arg_cnt == arg_need - 3'd1);
  assign tmo_hit   = TMO_EN && (tmo_cnt == TMO_W'(TIMEOUT));
  assign tx_accept = tx_we && !tx_wait;
  assign send_last = (byte_idx == 2'(DATA_BYTES - 1));
  assign addr_inc  = (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + 1'b1;
  assign mem_we    = (state == S_EXEC) && (cmd_q == CMD_W);
  assign rd_pad    = 32'(rd_word);

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (rx_valid) begin
          case (rx_data)
            CMD_A, CMD_W, CMD_B: state_nxt = S_ARGS;
            CMD_R:               state_nxt = S_RD_REQ;
            default:             state_nxt = S_RESP;
          endcase
        end
      S_ARGS:
        if (arg_last)     state_nxt = (cmd_q == CMD_B) ? S_RD_REQ : S_EXEC;
        else if (!rx_valid && tmo_hit) state_nxt = S_RESP;
      S_EXEC:    state_nxt = S_RESP;
      S_RD_REQ:  state_nxt = S_RD_WAIT;
      S_RD_WAIT: state_nxt = S_SEND;
      S_SEND:
        if (tx_accept && send_last) state_nxt = (burst_q != 8'd0) ? S_RD_REQ : S_IDLE;
      S_RESP:
        if (tx_accept) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_we   = 1'b0;
    tx_data = 8'h00;
    busy    = (state != S_IDLE);
    if (state == S_SEND) begin
      tx_we   = 1'b1;
      tx_data = rd_pad[byte_idx*8 +: 8];
    end else if (state == S_RESP) begin
      tx_we   = 1'b1;
      tx_data = resp_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cmd_q       <= '0;
      arg_q       <= '0;
      arg_cnt     <= '0;
      tmo_cnt     <= '0;
      burst_q     <= '0;
      byte_idx    <= '0;
      rd_word     <= '0;
      resp_q      <= '0;
      addr        <= '0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      // Bytes arriving while the engine is executing or replying are dropped.
      if (rx_valid && state != S_IDLE && state != S_ARGS) err_overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          arg_q    <= '0;
          arg_cnt  <= '0;
          tmo_cnt  <= '0;
          byte_idx <= '0;
          if (rx_valid) begin
            cmd_q   <= rx_data;
            burst_q <= '0;
            resp_q  <= 8'h3F;
          end
        end
        S_ARGS: begin
          if (rx_valid) begin
            arg_q[arg_cnt[1:0]*8 +: 8] <= rx_data;
            arg_cnt <= arg_cnt + 3'd1;
            tmo_cnt <= '0;
            if (arg_last && cmd_q == CMD_B) burst_q <= rx_data;
          end else if (tmo_hit) begin
            err_timeout <= 1'b1;
            resp_q      <= 8'h54;
          end else if (TMO_EN) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_EXEC: begin
          resp_q <= 8'h4B;
          if (cmd_q == CMD_A) addr <= ADDR_W'(arg_q % DEPTH_U);
          else                addr <= addr_inc;
        end
        S_RD_REQ:  byte_idx <= '0;
        S_RD_WAIT: rd_word  <= ram_q;
        S_SEND:
          if (tx_accept) begin
            if (send_last) begin
              byte_idx <= '0;
              addr     <= addr_inc;
              if (burst_q != 8'd0) burst_q <= burst_q - 8'd1;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)             mem[addr] <= arg_q[DATA_W-1:0];
    if (state == S_RD_REQ)  ram_q     <= mem[addr];
  end

endmodule

// File: tb/tb_uart_mem_cmd.sv
// Randomized bench for uart_mem_cmd against a word-level memory/pointer model.
module tb_uart_mem_cmd;
  localparam int DEP = 1000;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_we;
  logic       tx_wait = 1'b0;
  logic [9:0] addr;
  logic       busy, err_overrun, err_timeout;

  int         errors = 0;
  int         checks = 0;
  bit         stall = 1'b0;
  logic [7:0] got_q[$];
  int         mem_m[DEP];
  bit         known[DEP];
  int         addr_m = 0;

  uart_mem_cmd #(.DATA_W(12), .ADDR_W(10), .DEPTH(DEP), .TIMEOUT(50)) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_we(tx_we), .tx_wait(tx_wait), .addr(addr),
    .busy(busy), .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (tx_we && !tx_wait) got_q.push_back(tx_data);
  end

  initial forever begin
    @(posedge clk); #1;
    tx_wait = stall ? 1'b1 : ($urandom_range(0, 2) == 0);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Returns in the cycle right after the final strobe.
  task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int n, input bit b2b);
    logic [7:0] bs [3];
    bs[0] = b0; bs[1] = b1; bs[2] = b2;
    for (int i = 0; i < n; i++) begin
      rx_data  = bs[i];
      rx_valid = 1'b1;
      tick();
      if (!b2b || i == n - 1) rx_valid = 1'b0;
      if (!b2b && i != n - 1) repeat ($urandom_range(0, 4)) tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n);
    int cyc = 0;
    while (got_q.size() < n && cyc < 5000) begin tick(); cyc++; end
    if (got_q.size() < n) check_val("tx_byte_count", got_q.size(), n);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (busy && cyc < 5000) begin tick(); cyc++; end
    check_val("idle", busy, 0);
  endtask

  function automatic int pop_byte();
    if (got_q.size() == 0) return -1;
    return int'(got_q.pop_front());
  endfunction

  task automatic do_a(input int v, input bit b2b);
    send_cmd(8'h41, 8'(v), 8'(v >> 8), 3, b2b);
    check_val("A_lat_n1", tx_we, 0);
    tick();
    check_val("A_lat_n2", tx_we, 1);
    addr_m = v % DEP;
    wait_bytes(1);
    check_val("A_ack", pop_byte(), 'h4B);
    wait_idle();
    check_val("A_addr", addr, addr_m);
  endtask

  task automatic do_w(input int w, input bit b2b);
    send_cmd(8'h57, 8'(w), 8'(w >> 8), 3, b2b);
    check_val("W_lat_n1", tx_we, 0);
    tick();
    check_val("W_lat_n2", tx_we, 1);
    mem_m[addr_m] = w & 'hFFF;
    known[addr_m] = 1'b1;
    addr_m = (addr_m + 1) % DEP;
    wait_bytes(1);
    check_val("W_ack", pop_byte(), 'h4B);
    wait_idle();
    check_val("W_addr", addr, addr_m);
  endtask

  task automatic do_rd(input int words, input bit burst);
    int lo, hi;
    if (burst) send_cmd(8'h42, 8'(words - 1), 8'h00, 2, $urandom_range(0, 1) == 1);
    else       send_cmd(8'h52, 8'h00, 8'h00, 1, 1'b1);
    tick();
    check_val("R_lat_n2", tx_we, 0);
    tick();
    check_val("R_lat_n3", tx_we, 1);
    wait_bytes(2 * words);
    for (int i = 0; i < words; i++) begin
      lo = pop_byte();
      hi = pop_byte();
      if (known[addr_m]) begin
        check_val("R_lo", lo, mem_m[addr_m] & 'hFF);
        check_val("R_hi", hi, mem_m[addr_m] >> 8);
      end
      addr_m = (addr_m + 1) % DEP;
    end
    wait_idle();
    check_val("R_addr", addr, addr_m);
  endtask

  task automatic do_bad(input logic [7:0] b);
    send_cmd(b, 8'h00, 8'h00, 1, 1'b1);
    wait_bytes(1);
    check_val("bad_reply", pop_byte(), 'h3F);
    check_val("bad_busy", busy, 0);
    check_val("bad_addr", addr, addr_m);
  endtask

  initial begin
    int held_bad, r, v;
    logic [7:0] b;
    repeat (3) tick();
    check_val("rst_tx_we", tx_we, 0);
    check_val("rst_tx_data", tx_data, 0);
    check_val("rst_addr", addr, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_err_ovr", err_overrun, 0);
    check_val("rst_err_tmo", err_timeout, 0);
    resetn = 1'b1;
    tick();

    do_a(5, 1'b1);
    do_w('hFABC, 1'b1);
    do_a(5, 1'b0);
    do_rd(1, 1'b0);

    do_a(999, 1'b1);
    do_w('h11, 1'b0);
    do_w('h22, 1'b1);
    do_a(999, 1'b0);
    do_rd(2, 1'b1);

    do_bad(8'h00);

    send_cmd(8'h57, 8'h00, 8'h00, 1, 1'b1);
    wait_bytes(1);
    check_val("tmo_reply", pop_byte(), 'h54);
    check_val("tmo_flag", err_timeout, 1);
    wait_idle();
    check_val("tmo_addr", addr, addr_m);
    do_rd(1, 1'b0);
    check_val("no_overrun_yet", err_overrun, 0);

    do_a(5, 1'b1);
    stall = 1'b1;
    send_cmd(8'h52, 8'h00, 8'h00, 1, 1'b1);
    repeat (4) tick();
    held_bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (i == 100) send_cmd(8'h55, 8'h00, 8'h00, 1, 1'b1);
      if (tx_we !== 1'b1 || tx_data !== 8'hBC) held_bad++;
      tick();
    end
    check_val("stall_held", held_bad, 0);
    check_val("stall_no_accept", got_q.size(), 0);
    check_val("overrun_flag", err_overrun, 1);
    stall = 1'b0;
    wait_bytes(2);
    check_val("stall_lo", pop_byte(), 'hBC);
    check_val("stall_hi", pop_byte(), 'h0A);
    wait_idle();
    addr_m = 6;
    check_val("stall_addr", addr, addr_m);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 1) begin
        v = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(990, 65535);
        do_a(v, $urandom_range(0, 1) == 1);
      end else if (r <= 4) begin
        do_w($urandom_range(0, 65535), $urandom_range(0, 1) == 1);
      end else if (r <= 6) begin
        do_rd(1, 1'b0);
      end else if (r <= 8) begin
        do_rd($urandom_range(1, 8), 1'b1);
      end else begin
        b = 8'($urandom_range(0, 255));
        while (b == 8'h41 || b == 8'h57 || b == 8'h52 || b == 8'h42) b = 8'($urandom_range(0, 255));
        do_bad(b);
      end
    end

    send_cmd(8'h42, 8'hFF, 8'h00, 2, 1'b1);
    repeat (60) tick();
    resetn = 1'b0;
    tick();
    check_val("mid_rst_tx_we", tx_we, 0);
    check_val("mid_rst_addr", addr, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_err_tmo", err_timeout, 0);
    resetn = 1'b1;
    tick();
    tick();
    got_q.delete();
    addr_m = 0;
    do_rd(1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
